countdown_mod8: RTL and testbench

Programmable down-counter, the counterpart of the mod-8 up-counter. It counts from a reload value down to 0, then either wraps back to the reload value or stops, and emits a one-cycle terminal-count pulse. It sits beside the up-counter in timer and sequencing logic as the interval/timeout generator. With default parameters and auto-reload it behaves as a mod-8 down counter: 7, 6, … 0, 7.

---
 rtl/counter_pkg.sv | 11 +
 rtl/countdown_mod8.sv | 89 ++++++++
 tb/tb_countdown_mod8.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the mod-8 up-counter and the programmable down-counter.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  // FSM state encodings, shared with the up-counter
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] EXPIRED = 2'd2;

endpackage

// File: rtl/countdown_mod8.sv
// Programmable down-counter: counts from a reload value to 0, then wraps or stops,
// emitting a one-cycle registered terminal-count pulse.
module countdown_mod8
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned RELOAD_DEFAULT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  // Next-state, next-count and next-output logic; load overrides everything else
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      reload_d = load_value;
      count_d  = load_value;
      state_d  = RUN;
    end else begin
      case (state_q)
        IDLE, EXPIRED: begin
          if (start) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
        RUN: begin
          if (enable) begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Terminal-count edge: auto_reload is only looked at here
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                state_d = EXPIRED;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d == RUN);
  end

  // Single registered block; synchronous reset wins over all inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= WIDTH'(RELOAD_DEFAULT);
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_countdown_mod8.sv
// Directed, table-driven bench for countdown_mod8 with default parameters.
module tb_countdown_mod8;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load;
  logic [2:0] load_value;
  logic       start;
  logic       auto_reload;
  logic [2:0] count;
  logic       tc;
  logic       busy;

  int ncmp;
  int nbad;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic [2:0] lv;
    logic       st;
    logic       ar;
    logic [2:0] cnt;
    logic       tc;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  countdown_mod8 dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic l, input logic [2:0] lv,
                     input logic s, input logic a, input logic [2:0] c, input logic t,
                     input logic b);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.lv = lv; v.st = s; v.ar = a;
    v.cnt = c; v.tc = t; v.busy = b;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let one edge pass, then check the registered outputs
  task automatic apply(input logic r, input logic e, input logic l, input logic [2:0] lv,
                       input logic s, input logic a, input logic [2:0] c, input logic t,
                       input logic b, input string nm);
    reset = r; enable = e; load = l; load_value = lv; start = s; auto_reload = a;
    @(posedge clk);
    #1;
    ncmp++;
    if ({count, tc, busy} !== {c, t, b}) begin
      nbad++;
      $display("FAIL %s: got count=%0d tc=%0b busy=%0b, want count=%0d tc=%0b busy=%0b",
               nm, count, tc, busy, c, t, b);
    end
  endtask

  initial begin
    ncmp = 0;
    nbad = 0;
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = '0; start = 1'b0;
    auto_reload = 1'b0;

    // Reset two cycles, then IDLE must ignore enable
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Auto-reload from default 7: 7..0 then 7 with tc, twice
    add(0, 1, 0, 0, 1, 1, 7, 0, 1);
    for (int j = 6; j >= 0; j--) add(0, 1, 0, 0, 0, 1, 3'(j), 0, 1);
    add(0, 1, 0, 0, 0, 1, 7, 1, 1);
    for (int j = 6; j >= 0; j--) add(0, 1, 0, 0, 0, 1, 3'(j), 0, 1);
    add(0, 1, 0, 0, 0, 1, 7, 1, 1);

    // One-shot from load 3, hold in EXPIRED, restart with start
    add(0, 1, 1, 3, 0, 0, 3, 0, 1);
    add(0, 1, 0, 0, 0, 0, 2, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 3, 0, 1);

    // Alternating enable from 5; pause at 0 produces no tc
    add(0, 0, 1, 5, 0, 0, 5, 0, 1);
    add(0, 1, 0, 0, 0, 0, 4, 0, 1);
    add(0, 0, 0, 0, 0, 0, 4, 0, 1);
    add(0, 1, 0, 0, 0, 0, 3, 0, 1);
    add(0, 0, 0, 0, 0, 0, 3, 0, 1);
    add(0, 1, 0, 0, 0, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ar,
            vecs[i].cnt, vecs[i].tc, vecs[i].busy, $sformatf("vec%0d", i));
    end

    // Load mid-run at count 4: no decrement on the load edge
    apply(0, 0, 0, 0, 1, 0, 5, 0, 1, "restart5");
    apply(0, 1, 0, 0, 0, 0, 4, 0, 1, "dec4");
    apply(0, 1, 1, 2, 0, 0, 2, 0, 1, "load2_run");
    apply(0, 1, 0, 0, 0, 0, 1, 0, 1, "after_load2");

    // Load and start together from IDLE: load value wins over reload 7
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_a");
    apply(0, 1, 1, 6, 1, 0, 6, 0, 1, "load_vs_start");

    // Load 0, then load on the terminal-count edge suppresses tc
    apply(0, 0, 1, 0, 0, 0, 0, 0, 1, "load0");
    apply(0, 1, 1, 1, 0, 1, 1, 0, 1, "load_at_tc");
    apply(0, 1, 0, 0, 0, 1, 0, 0, 1, "dec0");
    apply(0, 1, 0, 0, 0, 1, 1, 1, 1, "auto_wrap1");
    apply(0, 1, 0, 0, 0, 1, 0, 0, 1, "dec0b");
    apply(0, 0, 0, 0, 0, 1, 0, 0, 1, "pause0");

    // Reset at count 3 in RUN, then start reloads the default 7
    apply(0, 0, 1, 3, 0, 0, 3, 0, 1, "load3");
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0, "rst_mid");
    apply(0, 1, 0, 0, 1, 0, 7, 0, 1, "start_default");

    // Reset on the terminal-count edge kills the pending tc
    apply(0, 0, 1, 0, 0, 0, 0, 0, 1, "load0b");
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0, "rst_at_tc");
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_rst");
    apply(0, 0, 0, 0, 1, 0, 7, 0, 1, "start_default2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
